// File: rtl/svga_timing.sv
// SVGA raster timing generator: pixel/line counters with registered sync, blanking
// and line/frame strobes, all aligned with the x/y registers they describe.
module svga_timing #(
  parameter int unsigned H_VIS    = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_VIS    = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_en,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        display,
  output logic        hsync,
  output logic        vsync,
  output logic        next_vertical,
  output logic        next_frame
);

  localparam int unsigned HTotal = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HMax       = 11'(HTotal - 1);
  localparam logic [10:0] HVis       = 11'(H_VIS);
  localparam logic [10:0] HSyncStart = 11'(H_VIS + H_FP);
  localparam logic [10:0] HSyncEnd   = 11'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VMax       = 10'(VTotal - 1);
  localparam logic [9:0]  VVis       = 10'(V_VIS);
  localparam logic [9:0]  VSyncStart = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VSyncEnd   = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        display_q, display_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        next_vertical_q, next_vertical_d;
  logic        next_frame_q, next_frame_d;

  // Next raster position: advance on pix_en, wrap line then frame.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_en) begin
      if (x_q == HMax) begin
        x_d = '0;
        y_d = (y_q == VMax) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end
  end

  // Decode the next position so the registered outputs line up with x/y.
  // With pix_en low x_d/y_d equal the current position, so outputs hold.
  always_comb begin
    display_d       = (x_d < HVis) && (y_d < VVis);
    hsync_d         = ((x_d >= HSyncStart) && (x_d <= HSyncEnd)) ? SYNC_POL : ~SYNC_POL;
    vsync_d         = ((y_d >= VSyncStart) && (y_d <= VSyncEnd)) ? SYNC_POL : ~SYNC_POL;
    next_vertical_d = (x_d == HVis) && (y_d < VVis);
    next_frame_d    = (x_d == HVis) && (y_d == VVis);
  end

  // State and output registers; reset values match the decode of (0,0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q             <= '0;
      y_q             <= '0;
      display_q       <= 1'b1;
      hsync_q         <= ~SYNC_POL;
      vsync_q         <= ~SYNC_POL;
      next_vertical_q <= 1'b0;
      next_frame_q    <= 1'b0;
    end else begin
      x_q             <= x_d;
      y_q             <= y_d;
      display_q       <= display_d;
      hsync_q         <= hsync_d;
      vsync_q         <= vsync_d;
      next_vertical_q <= next_vertical_d;
      next_frame_q    <= next_frame_d;
    end
  end

  assign x             = x_q;
  assign y             = y_q;
  assign display       = display_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign next_vertical = next_vertical_q;
  assign next_frame    = next_frame_q;

endmodule

// File: tb/tb_svga_timing.sv
// Bench for svga_timing: a small-timing instance (SYNC_POL=0) for whole-frame
// behaviour and a default instance for line-level timing, both scoreboarded
// every cycle against a bench-side raster model.
module tb_svga_timing;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic pix_en = 1'b0;

  logic [10:0] xs, xb;
  logic [9:0]  ys, yb;
  logic ds, hss, vss, nvs, nfs;
  logic db, hsb, vsb, nvb, nfb;

  always #5 clk = ~clk;

  svga_timing #(
    .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .x(xs), .y(ys), .display(ds), .hsync(hss), .vsync(vss),
    .next_vertical(nvs), .next_frame(nfs)
  );

  svga_timing u_big (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .x(xb), .y(yb), .display(db), .hsync(hsb), .vsync(vsb),
    .next_vertical(nvb), .next_frame(nfb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int msx = 0, msy = 0, mbx = 0, mby = 0;
  logic [25:0] q_s[$];
  logic [25:0] q_b[$];

  // Statistics gathered from the small instance
  bit count_en = 1'b0;
  int s_nv = 0, s_nf = 0, s_disp = 0, s_hs = 0, s_vs = 0;
  int b_hs = 0;
  int cyc = 0;
  int nf_rise0 = -1000, nf_rise1 = -1;
  int nf_rises = 0;
  logic nf_prev = 1'b0;

  function automatic logic [25:0] exp_vec(input int xx, input int yy,
                                          input int hv, input int hf, input int hs,
                                          input int vv, input int vf, input int vs,
                                          input bit pol);
    logic d, h, v, nv, nf;
    d  = (xx < hv) && (yy < vv);
    h  = (xx >= hv + hf && xx < hv + hf + hs) ? pol : ~pol;
    v  = (yy >= vv + vf && yy < vv + vf + vs) ? pol : ~pol;
    nv = (xx == hv) && (yy < vv);
    nf = (xx == hv) && (yy == vv);
    return {11'(xx), 10'(yy), d, h, v, nv, nf};
  endfunction

  function automatic logic [25:0] exp_small();
    return exp_vec(msx, msy, 8, 2, 2, 4, 1, 1, 1'b0);
  endfunction

  function automatic logic [25:0] exp_big();
    return exp_vec(mbx, mby, 800, 40, 128, 600, 1, 4, 1'b1);
  endfunction

  task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed x=%0d y=%0d flags=%b expected x=%0d y=%0d flags=%b",
             tag, obs[25:15], obs[14:5], obs[4:0], expv[25:15], expv[14:5], expv[4:0]);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic advance_models();
    msx++;
    if (msx == 14) begin
      msx = 0;
      msy = (msy == 6) ? 0 : msy + 1;
    end
    mbx++;
    if (mbx == 1056) begin
      mbx = 0;
      mby = (mby == 627) ? 0 : mby + 1;
    end
  endtask

  // One clock: drive pix_en, push model expectation, sample after the edge.
  task automatic step(input bit en);
    logic [25:0] es, eb;
    pix_en = en;
    if (en && reset_n) advance_models();
    q_s.push_back(exp_small());
    q_b.push_back(exp_big());
    @(posedge clk);
    #1;
    cyc++;
    es = q_s.pop_front();
    eb = q_b.pop_front();
    check("small_cycle", {xs, ys, ds, hss, vss, nvs, nfs}, es);
    check("big_cycle", {xb, yb, db, hsb, vsb, nvb, nfb}, eb);
    if (en && reset_n) begin
      if (hsb) b_hs++;
      if (count_en) begin
        if (nvs) s_nv++;
        if (nfs) s_nf++;
        if (ds) s_disp++;
        if (!hss) s_hs++;
        if (!vss) s_vs++;
      end
    end
    if (nfs && !nf_prev) begin
      nf_rise0 = nf_rise1;
      nf_rise1 = cyc;
      nf_rises++;
    end
    nf_prev = nfs;
  endtask

  // Assert reset between edges and check outputs without waiting for clk.
  task automatic reset_now();
    reset_n = 1'b0;
    msx = 0; msy = 0; mbx = 0; mby = 0;
    q_s.push_back(exp_small());
    q_b.push_back(exp_big());
    #1;
    check("small_reset", {xs, ys, ds, hss, vss, nvs, nfs}, q_s.pop_front());
    check("big_reset", {xb, yb, db, hsb, vsb, nvb, nfb}, q_b.pop_front());
  endtask

  initial begin
    #3;
    reset_now();
    step(1'b1);
    step(1'b1);   // reset held: no counting even with pix_en high
    #2 reset_n = 1'b1;
    step(1'b0);
    step(1'b0);   // released but idle: still (0,0)

    // Two small frames at full rate (14*7 = 98 clocks per frame).
    count_en = 1'b1;
    for (int i = 0; i < 196; i++) step(1'b1);
    count_en = 1'b0;
    check_int("small_next_vertical_count", s_nv, 8);
    check_int("small_next_frame_count", s_nf, 2);
    check_int("small_display_count", s_disp, 64);
    check_int("small_hsync_active_count", s_hs, 28);
    check_int("small_vsync_active_count", s_vs, 28);

    // pix_en toggling: frame period doubles.
    nf_rises = 0;
    for (int i = 0; i < 500; i++) step(i % 2 == 0);
    check_int("gated_frame_rises", (nf_rises >= 2) ? 1 : 0, 1);
    check_int("gated_frame_period", nf_rise1 - nf_rise0, 2 * 98);

    // Run the default instance to line 2, x=500.
    for (int i = 0; i < 4000 && !(mbx == 500 && mby == 2); i++) step(1'b1);
    check_int("big_reached_mid_line", (mbx == 500 && mby == 2) ? 1 : 0, 1);
    check_int("big_hsync_active_two_lines", b_hs, 256);

    // Mid-frame reset between edges, then restart.
    #2;
    reset_now();
    step(1'b1);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b1);
    check_int("restart_position", {21'(xb), 11'(yb)}, {21'd20, 11'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
